// File: rtl/mdu_iter_pkg.sv
// Shared MIPS multiply/divide encodings: operation codes, FSM states and decode helpers.
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_oper_e;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic oper_is_div(input mdu_oper_e op);
        return op[1];
    endfunction

    function automatic logic oper_is_signed(input mdu_oper_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the CPU datapath (master) and the multiply/divide unit (slave).
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    import mdu_iter_pkg::*;

    logic             flush;
    logic             start;
    mdu_oper_e        oper;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, oper, opa, opb, hi_wen, lo_wen, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, oper, opa, opb, hi_wen, lo_wen, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_iter_step.sv
// One iteration of the shared multiply/divide datapath: a shift-add step for
// multiply or a restoring-division step, both operating on unsigned magnitudes.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_cand;
    logic [WIDTH:0] sub_diff;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient bits}.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        sub_cand = acc[2*WIDTH-1:WIDTH-1];
        sub_diff = sub_cand - {1'b0, operand};
        acc_next = acc;
        if (is_div) begin
            if (!sub_diff[WIDTH]) begin
                acc_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {sub_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one result bit per
// enabled cycle, with CPU stall (cpu_en), flush and MTHI/MTLO write support.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         cpu_rst_n,
    input logic         cpu_en,
    mdu_iter_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               req_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (opb_q),
        .acc_next (step_acc)
    );

    // Operand magnitudes; negating the most-negative value yields its correct unsigned magnitude.
    always_comb begin
        req_div = oper_is_div(bus.oper);
        a_neg   = oper_is_signed(bus.oper) & bus.opa[WIDTH-1];
        b_neg   = oper_is_signed(bus.oper) & bus.opb[WIDTH-1];
        a_mag   = a_neg ? -bus.opa : bus.opa;
        b_mag   = b_neg ? -bus.opb : bus.opb;
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (cpu_en) begin
            if (bus.flush) begin
                state_d = MDU_ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    MDU_ST_IDLE: begin
                        if (bus.start) begin
                            is_div_d  = req_div;
                            busy_d    = 1'b1;
                            cnt_d     = CNT_W'(WIDTH);
                            opb_d     = b_mag;
                            // Divide by zero skips iteration; FIX then passes acc through unchanged.
                            if (req_div && (bus.opb == '0)) begin
                                state_d   = MDU_ST_FIX;
                                acc_d     = {bus.opa, {WIDTH{1'b1}}};
                                neg_d     = 1'b0;
                                rem_neg_d = 1'b0;
                            end else begin
                                state_d   = MDU_ST_CALC;
                                acc_d     = {{WIDTH{1'b0}}, a_mag};
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg & req_div;
                            end
                        end else begin
                            if (bus.hi_wen) begin
                                hi_d = bus.wdata;
                            end
                            if (bus.lo_wen) begin
                                lo_d = bus.wdata;
                            end
                        end
                    end
                    MDU_ST_CALC: begin
                        acc_d = step_acc;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = MDU_ST_FIX;
                        end
                    end
                    MDU_ST_FIX: begin
                        state_d = MDU_ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quot_fix;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
                    end
                    default: begin
                        state_d = MDU_ST_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= MDU_ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS CPU.
- Sits beside the ALU; the datapath issues MULT/MULTU/DIV/DIVU and stalls on `busy`.
- Supports MFHI/MFLO through continuous `hi`/`lo` outputs and MTHI/MTLO through direct write ports.
- Generalises the single-cycle ALU to multi-cycle operation with a start/busy/done handshake and stall/flush support.

Parameters:
- WIDTH, 32, operand width in bits; even, ≥4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override).

Ports:
- clk  in  1  main clock, rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- cpu_en  in  1  CPU enable; low freezes all state.
- flush  in  1  synchronous abort of the operation in flight.
- start  in  1  request; sampled only in IDLE with cpu_en=1.
- oper  in  2  MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3.
- opa  in  WIDTH  rs: multiplicand or dividend.
- opb  in  WIDTH  rt: multiplier or divisor.
- hi_wen  in  1  MTHI write.
- lo_wen  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when hi/lo are updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
  - Reset asserted mid-operation discards the operation; no done pulse follows.
- States: IDLE, CALC, FIX.
  - IDLE→CALC: start=1 & cpu_en=1 & flush=0. Latch oper; latch |opa| and |opb| (magnitudes for signed opers, raw values for unsigned); record result signs; counter=WIDTH; busy=1.
  - Divide by zero (DIV/DIVU with opb=0): IDLE→FIX directly.
  - CALC: one iteration per enabled edge; counter decrements; when counter reaches 0, CALC→FIX.
  - FIX→IDLE: apply sign correction, write hi/lo, assert done next cycle, busy=0.
- Multiply: radix-2 shift-add over magnitudes, 2*WIDTH-bit product; hi=upper half, lo=lower half. Signed product negated when operand signs differ.
- Divide: restoring, one quotient bit per iteration over magnitudes.
  - lo=quotient, truncated toward zero; negated when signs differ.
  - hi=remainder, carrying the sign of the dividend.
- Special cases:
  - Most-negative / -1 yields lo=most-negative, hi=0. This falls out of the magnitude arithmetic; no special case is needed.
  - Divide by zero: hi=opa, lo={WIDTH{1}}, done after 2 edges.
- Latency: start sampled at edge 0; CALC at edges 1..WIDTH; FIX at edge WIDTH+1. done is high in the cycle after edge WIDTH+1; busy is high from edge 0 through edge WIDTH+1.
- done: registered; high exactly one cycle; low otherwise, including under cpu_en=0.
- cpu_en=0: state, counter, hi, lo and the working registers hold; latency extends by the number of stalled cycles. If edge WIDTH+1 is stalled, done is deferred with it.
- flush=1 with cpu_en=1: any state→IDLE; busy=0; hi/lo unchanged; no done. flush has priority over start, hi_wen and lo_wen.
- hi_wen/lo_wen:
  - Take effect only in IDLE with cpu_en=1, no start and no flush.
  - Ignored while busy.
  - With start=1 in the same cycle, start wins and the write is discarded.
  - hi_wen and lo_wen together write both registers.
- start while busy: ignored; the operand inputs are don't-care after edge 0.
- Unknown oper: not possible, since all 4 codes are defined.

Decomposition:
- Add MDU_MULT/MULTU/DIV/DIVU and the state encodings to the shared MIPS define header, alongside the existing PC_/EXE_/WB_ constants.
- One natural combinational sub-module, mdu_step:
  - Inputs: mode, partial product or remainder, operand.
  - Output: next working state for one iteration.
  - Keeps the FSM/counter logic separate from the arithmetic.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 1 cycle, seen after edge 33.
- MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 100/0 → hi=0x64, lo=0xFFFFFFFF, done after edge 1.
- DIVU 1000/7 with cpu_en low for 5 cycles mid-CALC → done delayed by exactly 5 cycles; result lo=142, hi=6.
- MTHI 0x1234 in IDLE, then MULTU 2×3 with flush at edge 10 → hi=0x1234, lo=0 unchanged, no done; hi_wen while busy ignored.
- cpu_rst_n pulled low at edge 15 of DIV → busy=0, hi=lo=0 immediately; after release, start works normally.
